// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one pipelined FP adder among NUM_REQ requesters.
// A tag pipe travels alongside the adder so each result returns to its owner.
module fp_add_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 3,
    parameter int ID_WIDTH    = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic                              flush,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_ax,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_ay,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_result,
    output logic                              add_ena,
    output logic                              add_clr,
    output logic [DATA_WIDTH-1:0]             add_ax,
    output logic [DATA_WIDTH-1:0]             add_ay,
    input  logic [DATA_WIDTH-1:0]             add_result,
    output logic [$clog2(ADD_LATENCY+2)-1:0]  inflight,
    output logic                              idle
);

    localparam int CNT_W = $clog2(ADD_LATENCY+2);

    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   ptr_next;
    logic                  grant_any;
    logic [DATA_WIDTH-1:0] sel_ax;
    logic [DATA_WIDTH-1:0] sel_ay;
    logic [NUM_REQ-1:0]    rsp_onehot;
    logic                  tag_v  [ADD_LATENCY+1];
    logic [ID_WIDTH-1:0]   tag_id [ADD_LATENCY+1];

    // Two passes: first search from the pointer upward, then wrap to index 0.
    always_comb begin
        req_ready = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        if (rst_n && en && !flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && req_valid[i] && (i >= int'(rr_ptr))) begin
                    grant_any    = 1'b1;
                    req_ready[i] = 1'b1;
                    grant_id     = ID_WIDTH'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && req_valid[i]) begin
                    grant_any    = 1'b1;
                    req_ready[i] = 1'b1;
                    grant_id     = ID_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        sel_ax     = '0;
        sel_ay     = '0;
        rsp_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                sel_ax = req_ax[i*DATA_WIDTH +: DATA_WIDTH];
                sel_ay = req_ay[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (tag_id[ADD_LATENCY] == ID_WIDTH'(i)) begin
                rsp_onehot[i] = 1'b1;
            end
        end
        if (grant_id == ID_WIDTH'(NUM_REQ-1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_id + ID_WIDTH'(1);
        end
    end

    assign add_ena = en && rst_n;
    assign idle    = (inflight == '0) && (req_valid == '0);

    // The adder clear is delayed one cycle so it lands on the edge after flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_clr <= 1'b1;
        end else begin
            add_clr <= flush;
        end
    end

    // Flush wins over the enable; a stalled block keeps every register as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            add_ax     <= '0;
            add_ay     <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            inflight   <= '0;
            for (int i = 0; i <= ADD_LATENCY; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else if (flush) begin
            rsp_valid <= '0;
            inflight  <= '0;
            for (int i = 0; i <= ADD_LATENCY; i++) begin
                tag_v[i] <= 1'b0;
            end
        end else if (en) begin
            if (grant_any) begin
                rr_ptr <= ptr_next;
                add_ax <= sel_ax;
                add_ay <= sel_ay;
            end
            tag_v[0]  <= grant_any;
            tag_id[0] <= grant_id;
            for (int i = 1; i <= ADD_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            rsp_valid <= tag_v[ADD_LATENCY] ? rsp_onehot : '0;
            if (tag_v[ADD_LATENCY]) begin
                rsp_result <= add_result;
            end
            if (grant_any && !tag_v[ADD_LATENCY]) begin
                inflight <= inflight + CNT_W'(1);
            end else if (!grant_any && tag_v[ADD_LATENCY]) begin
                inflight <= inflight - CNT_W'(1);
            end
        end
    end

endmodule
